// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU between two requesters, with one op in flight.
// Each op runs IDLE -> EXEC -> RESP; the response is held until rsp_ready, and reqX_ready stays low meanwhile.
module alu_share_arbiter #(
  parameter int WIDTH       = 64,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry_out,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_ctrl;
  logic             op_id;

  logic             grant_id;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_carry;
  logic             alu_err;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  // The ALU only ever sees the latched operands.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op_ctrl)
      3'b000: alu_res = op_b;
      3'b010: begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b011: begin
        sum       = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b100: alu_res = op_a & op_b;
      3'b101: alu_res = op_a | op_b;
      3'b110: alu_res = op_a ^ op_b;
      default: alu_err = 1'b1;
    endcase
  end

  assign alu_neg  = !alu_err && alu_res[WIDTH-1];
  assign alu_zero = !alu_err && (alu_res == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      op_a          <= '0;
      op_b          <= '0;
      op_ctrl       <= '0;
      op_id         <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_negative  <= 1'b0;
      rsp_zero      <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_carry_out <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant_id ? req1_a    : req0_a;
            op_b       <= grant_id ? req1_b    : req0_b;
            op_ctrl    <= grant_id ? req1_ctrl : req0_ctrl;
            op_id      <= grant_id;
            last_grant <= grant_id;
            cnt        <= CNT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid     <= 1'b1;
            rsp_id        <= op_id;
            rsp_result    <= alu_res;
            rsp_negative  <= alu_neg;
            rsp_zero      <= alu_zero;
            rsp_overflow  <= alu_ovf;
            rsp_carry_out <= alu_carry;
            rsp_err       <= alu_err;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 1-cycle EXEC instance plus a 4-cycle instance fed from the same inputs.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err;

  logic        d4_req0_ready, d4_req1_ready, d4_rsp_valid, d4_rsp_id;
  logic [63:0] d4_rsp_result;
  logic        d4_rsp_negative, d4_rsp_zero, d4_rsp_overflow, d4_rsp_carry_out, d4_rsp_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(64), .EXEC_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_negative(rsp_negative), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_carry_out(rsp_carry_out), .rsp_err(rsp_err)
  );

  alu_share_arbiter #(.WIDTH(64), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id), .rsp_result(d4_rsp_result),
    .rsp_negative(d4_rsp_negative), .rsp_zero(d4_rsp_zero), .rsp_overflow(d4_rsp_overflow),
    .rsp_carry_out(d4_rsp_carry_out), .rsp_err(d4_rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    compared++; if (rsp_result !== 64'd0) begin mismatched++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
    compared++; if ({rsp_id, rsp_err, rsp_zero, rsp_carry_out} !== 4'b0000) begin mismatched++; $display("FAIL reset_rsp_flags got %b want 0000", {rsp_id, rsp_err, rsp_zero, rsp_carry_out}); end
    compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_ready_idle got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single_add();
    do_reset();
    req0_a = 64'd1; req0_b = 64'd1; req0_ctrl = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL add_exec_rsp_valid got %0b want 0", rsp_valid); end
    tick();
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL add_rsp_valid got %0b want 1", rsp_valid); end
    compared++; if (rsp_result !== 64'd2) begin mismatched++; $display("FAIL add_result got %h want 2", rsp_result); end
    compared++; if ({rsp_id, rsp_zero, rsp_carry_out, rsp_err} !== 4'b0000) begin mismatched++; $display("FAIL add_flags got %b want 0000", {rsp_id, rsp_zero, rsp_carry_out, rsp_err}); end
    tick();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL add_after_hs got %0b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic        exp_id;
    logic [63:0] exp_res;
    do_reset();
    req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'h7FFF_FFFF_FFFF_FFFF; req0_ctrl = 3'b011;
    req1_a = 64'h7FFF_FFFF_FFFF_FFFF; req1_b = 64'h7FFF_FFFF_FFFF_FFFF; req1_ctrl = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0;
      compared++; if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin mismatched++; $display("FAIL rr_grant%0d got %b want %b", k, {req0_ready, req1_ready}, {~exp_id, exp_id}); end
      tick();
      tick();
      compared++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) begin mismatched++; $display("FAIL rr_rsp%0d valid/id got %b want %b", k, {rsp_valid, rsp_id}, {1'b1, exp_id}); end
      compared++; if (rsp_result !== exp_res) begin mismatched++; $display("FAIL rr_result%0d got %h want %h", k, rsp_result, exp_res); end
      compared++; if ({rsp_zero, rsp_overflow, rsp_negative} !== {~exp_id, exp_id, exp_id}) begin mismatched++; $display("FAIL rr_flags%0d got %b want %b", k, {rsp_zero, rsp_overflow, rsp_negative}, {~exp_id, exp_id, exp_id}); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_a = 64'd5; req0_b = 64'd3; req0_ctrl = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_a = 64'hF0; req1_b = 64'hFF; req1_ctrl = 3'b110; req1_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      compared++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 64'd8}) begin mismatched++; $display("FAIL bp_hold%0d got v=%0b id=%0b r=%h want v=1 id=0 r=8", k, rsp_valid, rsp_id, rsp_result); end
      compared++; if (req1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_req1_ready%0d got %0b want 0", k, req1_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    compared++; if (req1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hs_ready got %0b want 0", req1_ready); end
    tick();
    compared++; if ({rsp_valid, req1_ready} !== 2'b01) begin mismatched++; $display("FAIL bp_after_hs got %b want 01", {rsp_valid, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    tick();
    compared++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 64'h0F}) begin mismatched++; $display("FAIL bp_req1_rsp got v=%0b id=%0b r=%h want v=1 id=1 r=0f", rsp_valid, rsp_id, rsp_result); end
    tick();
  endtask

  task automatic test_illegal_op();
    do_reset();
    req0_a = 64'd5; req0_b = 64'd5; req0_ctrl = 3'b111; req0_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    compared++; if ({rsp_valid, rsp_err} !== 2'b11) begin mismatched++; $display("FAIL ill_err got %b want 11", {rsp_valid, rsp_err}); end
    compared++; if (rsp_result !== 64'd0) begin mismatched++; $display("FAIL ill_result got %h want 0", rsp_result); end
    compared++; if ({rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out} !== 4'b0000) begin mismatched++; $display("FAIL ill_flags got %b want 0000", {rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out}); end
    tick();
    req0_a = 64'hFF; req0_b = 64'h0F; req0_ctrl = 3'b100; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    compared++; if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, 1'b0, 64'h0F}) begin mismatched++; $display("FAIL ill_next_legal got v=%0b err=%0b r=%h want v=1 err=0 r=0f", rsp_valid, rsp_err, rsp_result); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_a = 64'd9; req0_b = 64'd9; req0_ctrl = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_no_rsp%0d got %0b want 0", k, rsp_valid); end
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    compared++; if ({req0_ready, req1_ready} !== 2'b10) begin mismatched++; $display("FAIL rst_mid_tie got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_exec4_latency();
    do_reset();
    req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_ctrl = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    compared++; if (d4_req0_ready !== 1'b1) begin mismatched++; $display("FAIL e4_ready got %0b want 1", d4_req0_ready); end
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      compared++; if (d4_rsp_valid !== 1'b0) begin mismatched++; $display("FAIL e4_early%0d got %0b want 0", k, d4_rsp_valid); end
      tick();
    end
    compared++; if (d4_rsp_valid !== 1'b1) begin mismatched++; $display("FAIL e4_rsp_valid got %0b want 1", d4_rsp_valid); end
    compared++; if (d4_rsp_result !== 64'd0) begin mismatched++; $display("FAIL e4_result got %h want 0", d4_rsp_result); end
    compared++; if ({d4_rsp_zero, d4_rsp_carry_out, d4_rsp_err} !== 3'b110) begin mismatched++; $display("FAIL e4_flags got %b want 110", {d4_rsp_zero, d4_rsp_carry_out, d4_rsp_err}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_reset_mid_op();
    test_exec4_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
